// File: rtl/ahb_lite_cmd_mst.sv
// ahb_lite_cmd_mst: valid/ready commands to pipelined AHB-Lite single transfers.
// Optional: define AHB_LITE_CMD_MST_ALIGN_CHK_EN to retire misaligned commands as errors.
module ahb_lite_cmd_mst #(
  parameter logic [2:0] HPROT_HI    = 3'b001,
  parameter bit         ERR_REISSUE = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [63:0] cmd_wdata,
  input  logic        cmd_data,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [63:0] rsp_rdata,
  output logic [31:0] txn_cnt,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [63:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA
);

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        data;
    logic [63:0] wdata;
    logic        bypass;
  } slot_t;

  typedef enum logic {
    ST_RUN,
    ST_CANCEL
  } state_t;

  state_t      state_q, state_d;
  slot_t       a_q, a_d;
  slot_t       d_q, d_d;
  slot_t       cmd_slot;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] txn_cnt_q, txn_cnt_d;
  logic        cancel;
  logic        accept;
  logic        misalign;
  logic        retire_err;

  assign cancel    = (state_q == ST_CANCEL);
  assign cmd_ready = ~HRESET & ~cancel & (~a_q.valid | HREADY);
  assign accept    = cmd_valid & cmd_ready;

  // Misaligned commands become bus-less error entries when checking is built in
  always_comb begin
`ifdef AHB_LITE_CMD_MST_ALIGN_CHK_EN
    misalign = |(cmd_addr & ((32'd1 << cmd_size) - 32'd1));
`else
    misalign = 1'b0;
`endif
  end

  assign cmd_slot = '{
    valid:  1'b1,
    write:  cmd_write,
    addr:   cmd_addr,
    size:   cmd_size,
    data:   cmd_data,
    wdata:  cmd_wdata,
    bypass: misalign
  };

  // A cancelled data phase and bypass entries always retire as errors
  assign retire_err = HRESP | d_q.bypass | cancel;

  // Pipeline advance, error cancel sequencing and response generation
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    d_d         = d_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    txn_cnt_d   = txn_cnt_q;
    if (d_q.valid && HREADY) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = d_q.write;
      rsp_err_d   = retire_err;
      if (!d_q.write && !retire_err) begin
        rsp_rdata_d = HRDATA;
      end
      txn_cnt_d   = txn_cnt_q + 32'd1;
    end
    unique case (state_q)
      ST_RUN: begin
        if (HREADY) begin
          d_d = a_q;
          a_d = accept ? cmd_slot : '0;
        end else begin
          if (d_q.valid && HRESP) begin
            state_d = ST_CANCEL;
          end
          if (accept) begin
            a_d = cmd_slot;
          end
        end
      end
      ST_CANCEL: begin
        if (HREADY) begin
          state_d = ST_RUN;
          d_d     = '0;
          if (!ERR_REISSUE && a_q.valid) begin
            a_d.bypass = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State register; reset drops everything in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_RUN;
      a_q         <= '0;
      d_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      txn_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      d_q         <= d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  assign HTRANS    = (a_q.valid & ~cancel & ~a_q.bypass) ? 2'b10 : 2'b00;
  assign HSEL      = HTRANS[1];
  assign HADDR     = a_q.addr;
  assign HWRITE    = a_q.write;
  assign HSIZE     = a_q.size;
  assign HBURST    = 3'b000;
  assign HPROT     = {HPROT_HI, a_q.data};
  assign HWDATA    = d_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_ahb_lite_cmd_mst.sv
// tb_ahb_lite_cmd_mst: scoreboard bench with a simple AHB-Lite memory slave.
// Two masters share the slave: ERR_REISSUE=1 drives it, ERR_REISSUE=0 shadows.
`timescale 1ns/1ps
module tb_ahb_lite_cmd_mst;

  localparam logic [63:0] WD1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] WD2 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] WD3 = 64'h0123_4567_89AB_CDEF;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [63:0] cmd_wdata = '0;
  logic        cmd_data = 1'b0;

  logic        cmd_ready, rsp_valid, rsp_write, rsp_err;
  logic [63:0] rsp_rdata;
  logic [31:0] txn_cnt;
  logic        HSEL, HWRITE;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [63:0] HWDATA;

  logic        cmd_ready0, rsp_valid0, rsp_write0, rsp_err0;
  logic [63:0] rsp_rdata0;
  logic [31:0] txn_cnt0;
  logic        HSEL0, HWRITE0;
  logic [31:0] HADDR0;
  logic [1:0]  HTRANS0;
  logic [2:0]  HSIZE0, HBURST0;
  logic [3:0]  HPROT0;
  logic [63:0] HWDATA0;

  logic        HREADY, HRESP;
  logic [63:0] HRDATA;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  ahb_lite_cmd_mst #(.HPROT_HI(3'b001), .ERR_REISSUE(1'b1)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .txn_cnt(txn_cnt),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  ahb_lite_cmd_mst #(.HPROT_HI(3'b001), .ERR_REISSUE(1'b0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid0), .rsp_write(rsp_write0),
    .rsp_err(rsp_err0), .rsp_rdata(rsp_rdata0),
    .txn_cnt(txn_cnt0),
    .HSEL(HSEL0), .HADDR(HADDR0), .HTRANS(HTRANS0),
    .HWRITE(HWRITE0), .HSIZE(HSIZE0), .HBURST(HBURST0),
    .HPROT(HPROT0), .HWDATA(HWDATA0),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {16'hA5A5, a[15:3], 3'b000, 16'h5A5A, a[15:3], 3'b000};
  endfunction

  // Slave: memory, optional wait states and two-cycle error by address
  logic [63:0] mem [0:1023];
  bit          init_done;
  logic        dp_v, dp_w, err_st;
  logic [31:0] dp_a;
  int          wl;
  logic [31:0] ws_addr = 32'hFFFF_FFFF;
  int          ws_n = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  function logic [63:0] rdword(input logic [31:0] a);
    if (dp_v && dp_w && !HRESP && dp_a[12:3] == a[12:3])
      return HWDATA;
    return mem[a[12:3]];
  endfunction

  always @(posedge HCLK) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(32'(i) << 3);
      init_done <= 1'b1;
    end
    if (HRESET) begin
      HREADY <= 1'b1; HRESP <= 1'b0; HRDATA <= '0;
      dp_v <= 1'b0; dp_w <= 1'b0; dp_a <= '0;
      wl <= 0; err_st <= 1'b0;
    end else if (HREADY) begin
      if (dp_v && dp_w && !HRESP) mem[dp_a[12:3]] <= HWDATA;
      HRDATA <= '0;
      if (HSEL && HTRANS[1]) begin
        dp_v <= 1'b1; dp_w <= HWRITE; dp_a <= HADDR;
        if (HADDR == err_addr) begin
          HREADY <= 1'b0; HRESP <= 1'b1; err_st <= 1'b1;
        end else if (HADDR == ws_addr && ws_n > 0) begin
          HREADY <= 1'b0; HRESP <= 1'b0; wl <= ws_n - 1;
        end else begin
          HREADY <= 1'b1; HRESP <= 1'b0;
          if (!HWRITE) HRDATA <= rdword(HADDR);
        end
      end else begin
        dp_v <= 1'b0; HREADY <= 1'b1; HRESP <= 1'b0;
      end
    end else begin
      if (err_st) begin
        HREADY <= 1'b1; HRESP <= 1'b1; err_st <= 1'b0;
      end else if (wl == 0) begin
        HREADY <= 1'b1;
        if (!dp_w) HRDATA <= mem[dp_a[12:3]];
      end else begin
        wl <= wl - 1;
      end
    end
  end

  typedef struct {
    logic        w;
    logic        err;
    logic [63:0] rd;
    int          at;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  // Scoreboard for the ERR_REISSUE=1 master
  always @(negedge HCLK) begin : mon1
    exp_t e;
    if (rsp_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp1_unexpected cyc=%0d rdata=%h required none",
                 cyc, rsp_rdata);
      end else begin
        e = q1.pop_front();
        checks++;
        if (rsp_write !== e.w) begin
          errors++;
          $display("FAIL rsp1_write got=%b required=%b", rsp_write, e.w);
        end
        checks++;
        if (rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp1_err got=%b required=%b", rsp_err, e.err);
        end
        checks++;
        if (rsp_rdata !== e.rd) begin
          errors++;
          $display("FAIL rsp1_rdata got=%h required=%h", rsp_rdata, e.rd);
        end
        if (e.at >= 0) begin
          checks++;
          if (cyc != e.at) begin
            errors++;
            $display("FAIL rsp1_latency cyc=%0d required=%0d", cyc, e.at);
          end
        end
      end
    end
  end

  // Scoreboard for the ERR_REISSUE=0 master
  always @(negedge HCLK) begin : mon0
    exp_t e;
    if (rsp_valid0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp0_unexpected cyc=%0d rdata=%h required none",
                 cyc, rsp_rdata0);
      end else begin
        e = q0.pop_front();
        checks++;
        if (rsp_write0 !== e.w) begin
          errors++;
          $display("FAIL rsp0_write got=%b required=%b", rsp_write0, e.w);
        end
        checks++;
        if (rsp_err0 !== e.err) begin
          errors++;
          $display("FAIL rsp0_err got=%b required=%b", rsp_err0, e.err);
        end
        checks++;
        if (rsp_rdata0 !== e.rd) begin
          errors++;
          $display("FAIL rsp0_rdata got=%h required=%h", rsp_rdata0, e.rd);
        end
        if (e.at >= 0) begin
          checks++;
          if (cyc != e.at) begin
            errors++;
            $display("FAIL rsp0_latency cyc=%0d required=%0d", cyc, e.at);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [63:0] wd,
                      input logic dat, input bit push,
                      input logic e1, input logic [63:0] r1,
                      input logic e0, input logic [63:0] r0,
                      input int lat);
    int n;
    int acc;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a;
    cmd_size = sz; cmd_wdata = wd; cmd_data = dat;
    n = 0;
    #1;
    while (!cmd_ready && n < 40) begin
      @(negedge HCLK); #1; n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_accept addr=%h cmd_ready=%b required 1",
               a, cmd_ready);
      cmd_valid = 1'b0;
      @(negedge HCLK);
      return;
    end
    @(posedge HCLK);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    acc = cyc;
    if (push) begin
      q1.push_back('{w, e1, r1, (lat < 0) ? -1 : acc + lat - 1});
      q0.push_back('{w, e0, r0, (lat < 0) ? -1 : acc + lat - 1});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 60) begin
      @(negedge HCLK); n++;
    end
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d/%0d required 0/0",
               q1.size(), q0.size());
      q1.delete(); q0.delete();
    end
    repeat (2) @(negedge HCLK);
  endtask

  task automatic do_reset();
    HRESET = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    q1.delete(); q0.delete();
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    logic [209:0] obs;
    logic [209:0] req;
    req = {2'b00, 1'b0, 32'h0, 1'b0, 3'h0, 3'h0, 4'b0010, 64'h0,
           1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0};
    repeat (2) @(negedge HCLK);
    obs = {HTRANS, HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
           rsp_valid, rsp_err, rsp_write, rsp_rdata, txn_cnt, cmd_ready};
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL reset_outputs1 got=%h required=%h", obs, req);
    end
    obs = {HTRANS0, HSEL0, HADDR0, HWRITE0, HSIZE0, HBURST0, HPROT0,
           HWDATA0, rsp_valid0, rsp_err0, rsp_write0, rsp_rdata0,
           txn_cnt0, cmd_ready0};
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL reset_outputs0 got=%h required=%h", obs, req);
    end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_write_read();
    send(1'b1, 32'h1008, 3'd3, WD1, 1'b1, 1'b1,
         1'b0, 64'h0, 1'b0, 64'h0, 3);
    checks++;
    if ({HTRANS, HSEL, HADDR, HWRITE, HSIZE, HPROT, HBURST} !==
        {2'b10, 1'b1, 32'h1008, 1'b1, 3'd3, 4'b0011, 3'b000}) begin
      errors++;
      $display("FAIL wr_addr_phase htrans=%b haddr=%h hwrite=%b hsize=%0d hprot=%b required 10/1008/1/3/0011",
               HTRANS, HADDR, HWRITE, HSIZE, HPROT);
    end
    @(negedge HCLK);
    checks++;
    if (HTRANS !== 2'b00) begin
      errors++;
      $display("FAIL wr_single_nonseq htrans=%b required=00", HTRANS);
    end
    checks++;
    if (HWDATA !== WD1) begin
      errors++;
      $display("FAIL wr_hwdata got=%h required=%h", HWDATA, WD1);
    end
    drain();
    send(1'b0, 32'h1008, 3'd3, 64'h0, 1'b1, 1'b1,
         1'b0, WD1, 1'b0, WD1, 3);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [63:0] ex;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000 + 32'(i * 8);
      ex = (a == 32'h1008) ? WD1 : pat(a);
      send(1'b0, a, 3'd3, 64'h0, i[0], 1'b1,
           1'b0, ex, 1'b0, ex, 3);
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== a ||
          HPROT !== {3'b001, i[0]}) begin
        errors++;
        $display("FAIL b2b_nonseq%0d htrans=%b haddr=%h hprot=%b required 10/%h/%b",
                 i, HTRANS, HADDR, HPROT, a, {3'b001, i[0]});
      end
    end
    drain();
    checks++;
    if (txn_cnt !== 32'd4) begin
      errors++;
      $display("FAIL b2b_txn_cnt got=%0d required=4", txn_cnt);
    end
  endtask

  task automatic test_wait_states();
    ws_addr = 32'h1040; ws_n = 3;
    send(1'b1, 32'h1040, 3'd3, WD2, 1'b1, 1'b1,
         1'b0, 64'h0, 1'b0, 64'h0, 6);
    send(1'b1, 32'h1048, 3'd3, WD3, 1'b1, 1'b1,
         1'b0, 64'h0, 1'b0, 64'h0, 6);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (HREADY !== 1'b0 || HTRANS !== 2'b10 || HADDR !== 32'h1048 ||
          HWDATA !== WD2 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold%0d hready=%b htrans=%b haddr=%h hwdata=%h cmd_ready=%b required 0/10/1048/%h/0",
                 i, HREADY, HTRANS, HADDR, HWDATA, cmd_ready, WD2);
      end
      @(negedge HCLK);
    end
    ws_addr = 32'hFFFF_FFFF; ws_n = 0;
    drain();
    send(1'b0, 32'h1040, 3'd3, 64'h0, 1'b1, 1'b1,
         1'b0, WD2, 1'b0, WD2, 3);
    send(1'b0, 32'h1048, 3'd3, 64'h0, 1'b1, 1'b1,
         1'b0, WD3, 1'b0, WD3, 3);
    drain();
  endtask

  task automatic test_error();
    int hits1;
    int hits0;
    hits1 = 0; hits0 = 0;
    err_addr = 32'h1020;
    send(1'b0, 32'h1020, 3'd3, 64'h0, 1'b1, 1'b1,
         1'b1, 64'h0, 1'b1, 64'h0, 4);
    send(1'b0, 32'h1028, 3'd3, 64'h0, 1'b1, 1'b1,
         1'b0, pat(32'h1028), 1'b1, 64'h0, 5);
    checks++;
    if (HTRANS !== 2'b10 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_cycle1 htrans=%b cmd_ready=%b required 10/0",
               HTRANS, cmd_ready);
    end
    @(negedge HCLK);
    checks++;
    if (HTRANS !== 2'b00 || HTRANS0 !== 2'b00 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_cycle2_idle htrans=%b htrans0=%b cmd_ready=%b required 00/00/0",
               HTRANS, HTRANS0, cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10 && HADDR == 32'h1028 && HREADY) hits1++;
      if (HTRANS0 == 2'b10 && HADDR0 == 32'h1028 && HREADY) hits0++;
    end
    err_addr = 32'hFFFF_FFFF;
    checks++;
    if (hits1 != 1) begin
      errors++;
      $display("FAIL err_reissue1 nonseq_count=%0d required=1", hits1);
    end
    checks++;
    if (hits0 != 0) begin
      errors++;
      $display("FAIL err_reissue0 nonseq_count=%0d required=0", hits0);
    end
    drain();
  endtask

  task automatic test_misaligned();
`ifdef AHB_LITE_CMD_MST_ALIGN_CHK_EN
    send(1'b0, 32'h1002, 3'd2, 64'h0, 1'b1, 1'b1,
         1'b1, 64'h0, 1'b1, 64'h0, 3);
    checks++;
    if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin
      errors++;
      $display("FAIL misalign_bypass htrans=%b hsel=%b required 00/0",
               HTRANS, HSEL);
    end
`else
    send(1'b0, 32'h1002, 3'd2, 64'h0, 1'b1, 1'b1,
         1'b0, pat(32'h1000), 1'b0, pat(32'h1000), 3);
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h1002 || HSIZE !== 3'd2) begin
      errors++;
      $display("FAIL misalign_issue htrans=%b haddr=%h hsize=%0d required 10/1002/2",
               HTRANS, HADDR, HSIZE);
    end
`endif
    drain();
  endtask

  task automatic test_reset_inflight();
    send(1'b1, 32'h1100, 3'd3, WD3, 1'b1, 1'b0,
         1'b0, 64'h0, 1'b0, 64'h0, -1);
    send(1'b0, 32'h1108, 3'd3, 64'h0, 1'b1, 1'b0,
         1'b0, 64'h0, 1'b0, 64'h0, -1);
    HRESET = 1'b1;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || txn_cnt !== 32'd0 ||
        cmd_ready !== 1'b0 || HTRANS0 !== 2'b00) begin
      errors++;
      $display("FAIL reset_async htrans=%b rsp_valid=%b txn_cnt=%0d cmd_ready=%b required 00/0/0/0",
               HTRANS, rsp_valid, txn_cnt, cmd_ready);
    end
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (8) @(negedge HCLK);
    checks++;
    if (txn_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_stale txn_cnt=%0d required=0", txn_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_misaligned();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_cmd_mst.md
Name: ahb_lite_cmd_mst

Overview:
- Testbench-side AHB-Lite master that turns simple valid/ready commands into single AHB-Lite transfers, with address and data phases pipelined.
- Sits directly upstream of the AHB-Lite memory/mailbox slave model and drives its HSEL/HADDR/HTRANS/HWRITE/HSIZE/HPROT/HWDATA.
- Returns read data and completion/error responses in command order.
- Used for directed bus traffic: preloading and checking memory, poking the mailbox.

Parameters:
- HPROT_HI, 3'b001, drives HPROT[3:1]; HPROT[0] comes per command.
- ERR_REISSUE, 1, behaviour of an address phase cancelled by an error response. 1 = re-issue it after the error. 0 = retire it with rsp_err=1 and never put it on the bus.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on edge when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_size  in  3  HSIZE encoding, 0..3 legal
- cmd_wdata  in  64  write data, already placed in its byte lanes
- cmd_data  in  1  HPROT[0]: 1 = data access, 0 = opcode fetch
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_write  out  1  completed command was a write
- rsp_err  out  1  completed with error
- rsp_rdata  out  64  read data; 0 for writes and errors
- txn_cnt  out  32  responses issued, wraps
- HSEL HADDR[31:0] HTRANS[1:0] HWRITE HSIZE[2:0] HBURST[2:0] HPROT[3:0] HWDATA[63:0]  out  AHB-Lite master outputs
- HREADY  in  1  bus ready (slave HREADYOUT)
- HRESP  in  1  error response
- HRDATA  in  64  read data; valid only while HREADY=1

Behaviour:
- Two register slots: A (address phase) and D (data phase). Each holds valid, write, addr, size, data, wdata and a bypass flag.
- All AHB outputs come from registers.
  - HTRANS = NONSEQ (2'b10) when A.valid & ~cancel & ~A.bypass; otherwise IDLE (2'b00).
  - HSEL = HTRANS[1]. HBURST = 3'b000. HPROT = {HPROT_HI, A.data}.
  - HWDATA = D.wdata. It is held stable while HREADY=0.
- cmd_ready = ~HRESET & ~cancel & (~A.valid | HREADY).
- Advance rule, on an edge with HREADY=1 & ~cancel:
  - D takes A (or becomes empty).
  - A takes the accepted command (or becomes empty).
  - If D.valid at that edge, it retires.
- While HREADY=0, A and D are held and bus outputs are stable. A may still load if it was empty.
- Retire: rsp_valid=1 on the next cycle, with rsp_write=D.write, rsp_err=HRESP|D.bypass, rsp_rdata = captured HRDATA (read, no error) else 0.
  - txn_cnt increments on every response. 0xFFFF_FFFF wraps to 0.
- Latency with 0 wait states:
  - accept edge N; address phase in cycle N+1; data phase in cycle N+2; rsp_valid in cycle N+3.
  - Each wait state adds 1 cycle.
  - Back-to-back throughput is 1 per cycle, and responses keep command order.
- Error, two-cycle:
  - Edge with D.valid & HREADY=0 & HRESP=1: set cancel. HTRANS goes IDLE in the second error cycle and A is held.
  - Next edge with HREADY=1: D retires with rsp_err=1 and cancel clears. A does not move to D.
    - ERR_REISSUE=1: A is re-driven as NONSEQ the following cycle.
    - ERR_REISSUE=0: A.bypass is set, and A retires as an error through D with no bus activity.
- HRESP=1 with HREADY=1 and no preceding HREADY=0 cycle: D still retires with rsp_err=1; nothing is cancelled.
- Bypass entries move through A and D at normal timing but drive IDLE, so response order is preserved.
- Reset (async, any time): A, D and cancel are cleared and in-flight commands are dropped without responses.
  - Output reset values: HTRANS=0, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HPROT={HPROT_HI,1'b0}, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_write=0, rsp_rdata=0, txn_cnt=0, cmd_ready=0.
- cmd_size > 3 is illegal. Only the 64-bit bus is supported.

Optional Feature:
- Macro: AHB_LITE_CMD_MST_ALIGN_CHK_EN.
- Defined: on accept, a command with cmd_addr not aligned to 2^cmd_size is loaded into A with bypass=1. It is never driven on the bus and retires with rsp_err=1 at normal latency.
- Undefined: no check. The command is issued as given.

Test Plan:
- Reset, write addr 0x0000_1008 size 3 wdata 0x1122_3344_5566_7788, 0 wait states -> NONSEQ for 1 cycle, HWDATA valid next cycle, rsp_valid 3 cycles after accept with rsp_err=0. A read of the same address returns 0x1122_3344_5566_7788.
- 4 back-to-back reads 0x1000/0x1008/0x1010/0x1018, 0 wait states -> HTRANS NONSEQ for 4 consecutive cycles, rsp_valid for 4 consecutive cycles in order, txn_cnt=4.
- Slave inserts 3 wait states on a write -> HADDR and HWDATA stable for all 3 cycles, response latency 6, cmd_ready low while A is full and HREADY=0.
- Two-cycle HRESP on a read with a second read pending in A:
  - ERR_REISSUE=1 -> HTRANS IDLE in the 2nd error cycle, rsp_err=1 with rdata=0, then the pending read is re-issued and returns data with rsp_err=0.
  - ERR_REISSUE=0 -> the pending read returns rsp_err=1 and never appears on the bus.
- HRESET pulsed with 2 commands in flight -> HTRANS=0 and rsp_valid=0 immediately, txn_cnt=0, no stale responses after release.
- With the macro defined: size 2 at addr 0x0000_1002 -> no NONSEQ, rsp_err=1 3 cycles after accept. Without the macro: NONSEQ issued with HADDR=0x0000_1002.
